arbitro_memoria: RTL

- Two-port arbiter and sequencer for the shared 256 x 8-bit data memory bank.
- Requester 0 is the processor load/store path; requester 1 is the debug/loader port.
- Grants one requester at a time with round-robin fairness.
- Drives the bank's write-enable, read-enable, address and write-data lines from registers, and returns registered read data with a valid pulse.

---
 rtl/arbitro_memoria_if.sv | 38 +++
 rtl/arbitro_memoria.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_if.sv
// Bundle shared by the arbiter and its requesters/bank: both request ports,
// shared read-data return and the bank-side strobes and buses.
interface arbitro_memoria_if #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_END  = 8
);
  logic                    req0;
  logic                    esc0;
  logic [LARGURA_END-1:0]  end0;
  logic [LARGURA_DADO-1:0] dado0;
  logic                    gnt0;
  logic                    req1;
  logic                    esc1;
  logic [LARGURA_END-1:0]  end1;
  logic [LARGURA_DADO-1:0] dado1;
  logic                    gnt1;
  logic [LARGURA_DADO-1:0] dado_lido;
  logic                    valido0;
  logic                    valido1;
  logic                    ocupado;
  logic                    mem_escreve;
  logic                    mem_le;
  logic [LARGURA_END-1:0]  mem_endereco;
  logic [LARGURA_DADO-1:0] mem_dado_salvo;
  logic [LARGURA_DADO-1:0] mem_dado_carregado;

  modport slave (
    input  req0, esc0, end0, dado0, req1, esc1, end1, dado1, mem_dado_carregado,
    output gnt0, gnt1, dado_lido, valido0, valido1, ocupado,
           mem_escreve, mem_le, mem_endereco, mem_dado_salvo
  );

  modport master (
    output req0, esc0, end0, dado0, req1, esc1, end1, dado1, mem_dado_carregado,
    input  gnt0, gnt1, dado_lido, valido0, valido1, ocupado,
           mem_escreve, mem_le, mem_endereco, mem_dado_salvo
  );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer for the shared data bank (round-robin by default).
// Define ARBITRO_PRIORIDADE_FIXA_EN for fixed priority: requester 0 wins ties.
module arbitro_memoria #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_END  = 8
) (
  input logic              clock,
  input logic              reset,
  arbitro_memoria_if.slave bus
);
  localparam logic [1:0] OCIOSO   = 2'd0;
  localparam logic [1:0] ACESSO   = 2'd1;
  localparam logic [1:0] RESPOSTA = 2'd2;

  logic [1:0]              estado_q, estado_d;
  logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                    valido0_q, valido0_d, valido1_q, valido1_d;
  logic                    ocupado_q, ocupado_d;
  logic                    mem_escreve_q, mem_escreve_d, mem_le_q, mem_le_d;
  logic [LARGURA_END-1:0]  mem_endereco_q, mem_endereco_d;
  logic [LARGURA_DADO-1:0] mem_dado_salvo_q, mem_dado_salvo_d;
  logic [LARGURA_DADO-1:0] dado_lido_q, dado_lido_d;
  logic                    vence_s;
  logic                    esc_s;

`ifndef ARBITRO_PRIORIDADE_FIXA_EN
  logic ultimo_q, ultimo_d;
`endif

  // vence_s = 1 selects requester 1; only meaningful when some req is high
  always_comb begin
`ifdef ARBITRO_PRIORIDADE_FIXA_EN
    vence_s = ~bus.req0;
`else
    if (bus.req0 && bus.req1) begin
      vence_s = ~ultimo_q;
    end else begin
      vence_s = bus.req1;
    end
`endif
    esc_s = vence_s ? bus.esc1 : bus.esc0;
  end

  always_comb begin
    estado_d         = estado_q;
    gnt0_d           = 1'b0;
    gnt1_d           = 1'b0;
    valido0_d        = 1'b0;
    valido1_d        = 1'b0;
    mem_escreve_d    = 1'b0;
    mem_le_d         = 1'b0;
    mem_endereco_d   = mem_endereco_q;
    mem_dado_salvo_d = mem_dado_salvo_q;
    dado_lido_d      = dado_lido_q;
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
    ultimo_d         = ultimo_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (bus.req0 || bus.req1) begin
          estado_d         = ACESSO;
          gnt0_d           = ~vence_s;
          gnt1_d           = vence_s;
          mem_escreve_d    = esc_s;
          mem_le_d         = ~esc_s;
          mem_endereco_d   = vence_s ? bus.end1 : bus.end0;
          mem_dado_salvo_d = vence_s ? bus.dado1 : bus.dado0;
`ifndef ARBITRO_PRIORIDADE_FIXA_EN
          ultimo_d         = vence_s;
`endif
        end else begin
          estado_d = OCIOSO;
        end
      end
      ACESSO: begin
        // The bank's read data is valid while mem_le is up; capture it as ACESSO ends.
        if (mem_le_q) begin
          estado_d    = RESPOSTA;
          dado_lido_d = bus.mem_dado_carregado;
          valido0_d   = gnt0_q;
          valido1_d   = gnt1_q;
        end else begin
          estado_d = OCIOSO;
        end
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q         <= OCIOSO;
      gnt0_q           <= 1'b0;
      gnt1_q           <= 1'b0;
      valido0_q        <= 1'b0;
      valido1_q        <= 1'b0;
      ocupado_q        <= 1'b0;
      mem_escreve_q    <= 1'b0;
      mem_le_q         <= 1'b0;
      mem_endereco_q   <= {LARGURA_END{1'b0}};
      mem_dado_salvo_q <= {LARGURA_DADO{1'b0}};
      dado_lido_q      <= {LARGURA_DADO{1'b0}};
    end else begin
      estado_q         <= estado_d;
      gnt0_q           <= gnt0_d;
      gnt1_q           <= gnt1_d;
      valido0_q        <= valido0_d;
      valido1_q        <= valido1_d;
      ocupado_q        <= ocupado_d;
      mem_escreve_q    <= mem_escreve_d;
      mem_le_q         <= mem_le_d;
      mem_endereco_q   <= mem_endereco_d;
      mem_dado_salvo_q <= mem_dado_salvo_d;
      dado_lido_q      <= dado_lido_d;
    end
  end

`ifndef ARBITRO_PRIORIDADE_FIXA_EN
  // Starts at 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ultimo_q <= 1'b1;
    end else begin
      ultimo_q <= ultimo_d;
    end
  end
`endif

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.valido0        = valido0_q;
  assign bus.valido1        = valido1_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.dado_lido      = dado_lido_q;
  assign bus.mem_escreve    = mem_escreve_q;
  assign bus.mem_le         = mem_le_q;
  assign bus.mem_endereco   = mem_endereco_q;
  assign bus.mem_dado_salvo = mem_dado_salvo_q;
endmodule
